// File: rtl/square_wave_meter.sv
// Square-wave high/low time meter with sticky stall timeout.
// Optional input glitch filter: define GLITCH_FILTER_EN.
module square_wave_meter #(
  parameter int W          = 27,
  parameter int TIMEOUT    = 125_000_000,
  parameter int FILTER_LEN = 4
) (
  input  logic         clk,
  input  logic         rst_btn,
  input  logic         sig_in,
  output logic [W-1:0] high_cycles,
  output logic [W-1:0] low_cycles,
  output logic         meas_valid,
  output logic         timeout,
  output logic         level
);

  if (TIMEOUT < 2 || FILTER_LEN < 2) begin : g_bad_param
    $error("square_wave_meter: bad TIMEOUT or FILTER_LEN");
  end

  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] TO_LM = W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  logic [1:0] rst_q;
  logic       rst_i;

  // async assert, release after two clk edges
  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) rst_q <= 2'b11;
    else         rst_q <= {rst_q[0], 1'b0};
  end

  assign rst_i = rst_q[1];

  logic [1:0] sync_q;
  logic       s;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], sig_in};
  end

  assign s = sync_q[1];

  logic lvl;

`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN);

  logic [FW-1:0] stab_q;
  logic          filt_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      stab_q <= '0;
      filt_q <= 1'b0;
    end else if (s == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == FW'(FILTER_LEN - 1)) begin
      stab_q <= '0;
      filt_q <= s;
    end else begin
      stab_q <= stab_q + 1'b1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s;
`endif

  logic lvl_d_q;
  logic rise;
  logic fall;

  assign rise = lvl & ~lvl_d_q;
  assign fall = ~lvl & lvl_d_q;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   hi_tmp_q, hi_tmp_d;
  logic [W-1:0]   high_q, high_d;
  logic [W-1:0]   low_q, low_d;
  logic           valid_q, valid_d;
  logic           to_q, to_d;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      lvl_d_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_tmp_q <= '0;
      high_q   <= '0;
      low_q    <= '0;
      valid_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      lvl_d_q  <= lvl;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_tmp_q <= hi_tmp_d;
      high_q   <= high_d;
      low_q    <= low_d;
      valid_q  <= valid_d;
      to_q     <= to_d;
    end
  end

  // an edge in the same cycle as the limit wins over timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_tmp_d = hi_tmp_q;
    high_d   = high_q;
    low_d    = low_q;
    valid_d  = 1'b0;
    to_d     = to_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = ONE;
          to_d    = 1'b0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_tmp_d = cnt_q;
          cnt_d    = ONE;
          state_d  = LOW;
        end else if (cnt_q == TO_LM) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LOW: begin
        if (rise) begin
          high_d  = hi_tmp_q;
          low_d   = cnt_q;
          valid_d = 1'b1;
          cnt_d   = ONE;
          state_d = HIGH;
        end else if (cnt_q == TO_LM) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign high_cycles = high_q;
  assign low_cycles  = low_q;
  assign meas_valid  = valid_q;
  assign timeout     = to_q;
  assign level       = lvl;

endmodule

// File: tb/tb_square_wave_meter.sv
// Directed bench for square_wave_meter (W=8, TIMEOUT=200).
// Glitch expectations follow GLITCH_FILTER_EN if defined.
module tb_square_wave_meter;

  localparam int W = 8;

  logic         clk;
  logic         rst_btn;
  logic         sig_in;
  logic [W-1:0] high_cycles;
  logic [W-1:0] low_cycles;
  logic         meas_valid;
  logic         timeout;
  logic         level;

  square_wave_meter #(
    .W         (W),
    .TIMEOUT   (200),
    .FILTER_LEN(4)
  ) dut (
    .clk        (clk),
    .rst_btn    (rst_btn),
    .sig_in     (sig_in),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;

  int vcnt = 0;
  int log_hi [64];
  int log_lo [64];

  always @(negedge clk) begin
    if (meas_valid) begin
      log_hi[vcnt % 64] <= int'(high_cycles);
      log_lo[vcnt % 64] <= int'(low_cycles);
      vcnt <= vcnt + 1;
    end
  end

  typedef struct {
    int hi;
    int lo;
    int nper;
    int ehi;
    int elo;
    int en;
    int eto;
  } vec_t;

  vec_t tv [7];

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic v, int n);
    sig_in = v;
    tick(n);
  endtask

  task automatic do_reset();
    rst_btn = 1'b1;
    sig_in  = 1'b0;
    tick(3);
    rst_btn = 1'b0;
    tick(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gn, ghi, glo, g0hi, g0lo;

    tv[0] = '{hi: 10,  lo: 6,   nper: 5, ehi: 10,  elo: 6,   en: 5, eto: 0};
    tv[1] = '{hi: 1,   lo: 1,   nper: 6, ehi: 1,   elo: 1,   en: 6, eto: 0};
    tv[2] = '{hi: 3,   lo: 7,   nper: 3, ehi: 3,   elo: 7,   en: 3, eto: 0};
    tv[3] = '{hi: 2,   lo: 3,   nper: 4, ehi: 2,   elo: 3,   en: 4, eto: 0};
    tv[4] = '{hi: 200, lo: 5,   nper: 2, ehi: 200, elo: 5,   en: 2, eto: 0};
    tv[5] = '{hi: 5,   lo: 200, nper: 2, ehi: 5,   elo: 200, en: 2, eto: 0};
    tv[6] = '{hi: 201, lo: 5,   nper: 2, ehi: 0,   elo: 0,   en: 0, eto: 0};

    rst_btn = 1'b1;
    sig_in  = 1'b0;
    tick(3);
    chk("rst_high", int'(high_cycles), 0);
    chk("rst_low", int'(low_cycles), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_level", int'(level), 0);
    rst_btn = 1'b0;
    tick(4);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      base = vcnt;
      for (int p = 0; p < tv[i].nper; p++) begin
        drive(1'b1, tv[i].hi);
        drive(1'b0, tv[i].lo);
      end
      drive(1'b1, 4);
      tick(6);
      chk($sformatf("vec%0d_count", i), vcnt - base, tv[i].en);
      chk($sformatf("vec%0d_high", i), int'(high_cycles), tv[i].ehi);
      chk($sformatf("vec%0d_low", i), int'(low_cycles), tv[i].elo);
      chk($sformatf("vec%0d_timeout", i), int'(timeout), tv[i].eto);
      for (int k = base; k < vcnt; k++) begin
        chk($sformatf("vec%0d_log_hi", i), log_hi[k % 64], tv[i].ehi);
        chk($sformatf("vec%0d_log_lo", i), log_lo[k % 64], tv[i].elo);
      end
    end

    // first-result latency: pulse three edges after second rise
    do_reset();
    base = vcnt;
    drive(1'b1, 10);
    drive(1'b0, 6);
    sig_in = 1'b1;
    tick(2);
    chk("lat_valid_early", int'(meas_valid), 0);
    tick(1);
    chk("lat_valid", int'(meas_valid), 1);
    chk("lat_high", int'(high_cycles), 10);
    chk("lat_low", int'(low_cycles), 6);

    // stall high: limit reached 202 edges after drive, flag one later
    tick(199);
    chk("to_before", int'(timeout), 0);
    tick(1);
    chk("to_set", int'(timeout), 1);
    tick(47);
    chk("to_sticky", int'(timeout), 1);
    chk("to_high_kept", int'(high_cycles), 10);
    chk("to_low_kept", int'(low_cycles), 6);
    chk("to_no_valid", vcnt - base, 1);
    drive(1'b0, 6);
    drive(1'b1, 10);
    chk("to_clear", int'(timeout), 0);
    chk("to_clear_no_valid", vcnt - base, 1);
    drive(1'b0, 6);
    sig_in = 1'b1;
    tick(4);
    chk("to_after_count", vcnt - base, 2);
    chk("to_after_hi", log_hi[(vcnt - 1) % 64], 10);
    chk("to_after_lo", log_lo[(vcnt - 1) % 64], 6);

    // reset during HIGH with sig_in held high
    #2;
    rst_btn = 1'b1;
    #1;
    chk("mid_rst_high", int'(high_cycles), 0);
    chk("mid_rst_low", int'(low_cycles), 0);
    chk("mid_rst_valid", int'(meas_valid), 0);
    chk("mid_rst_timeout", int'(timeout), 0);
    tick(2);
    rst_btn = 1'b0;
    tick(3);
    chk("rel_level_held", int'(level), 0);
    tick(1);
    chk("rel_level_up", int'(level), 1);
    base = vcnt;
    drive(1'b0, 6);
    chk("rel_no_valid", vcnt - base, 0);
    chk("rel_high_zero", int'(high_cycles), 0);
    sig_in = 1'b1;
    tick(4);
    chk("rel_count", vcnt - base, 1);
    chk("rel_log_hi", log_hi[(vcnt - 1) % 64], 2);
    chk("rel_log_lo", log_lo[(vcnt - 1) % 64], 6);

    // 2-cycle low glitch inside each 10-cycle high
`ifdef GLITCH_FILTER_EN
    gn = 3; ghi = 10; glo = 6; g0hi = 10; g0lo = 6;
`else
    gn = 6; ghi = 4; glo = 6; g0hi = 4; g0lo = 2;
`endif
    do_reset();
    base = vcnt;
    repeat (3) begin
      drive(1'b1, 4);
      drive(1'b0, 2);
      drive(1'b1, 4);
      drive(1'b0, 6);
    end
    drive(1'b1, 4);
    tick(6);
    chk("glitch_count", vcnt - base, gn);
    chk("glitch_first_hi", log_hi[base % 64], g0hi);
    chk("glitch_first_lo", log_lo[base % 64], g0lo);
    chk("glitch_high", int'(high_cycles), ghi);
    chk("glitch_low", int'(low_cycles), glo);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/square_wave_meter.md
# square_wave_meter

Measures the high time and low time of an external square-wave input, in `clk` cycles, and reports one result per full period. It is the receive-side counterpart of the board's LED blink generators. It is used on an input pin or loopback wire to check the frequency and duty cycle of a toggling signal, such as a 1 Hz blink at 125 MHz. Results are held in registers with a one-cycle valid strobe, plus a timeout flag for a stalled input.

## Interface
- `W`, 27: width of the cycle counters and result outputs.
- `TIMEOUT`, 125_000_000: number of cycles without an edge before `timeout` asserts. Must satisfy 2 ≤ `TIMEOUT` ≤ 2^W−1.
- `FILTER_LEN`, 4: glitch-filter stability length in cycles. Only used when `GLITCH_FILTER_EN` is defined. Must be ≥ 2.
- `clk` in 1: system clock.
- `rst_btn` in 1: reset. Asynchronous, active-high.
- `sig_in` in 1: measured signal. Asynchronous to `clk`.
- `high_cycles` out W: most recent completed high duration.
- `low_cycles` out W: most recent completed low duration.
- `meas_valid` out 1: one-cycle pulse when `high_cycles`/`low_cycles` update.
- `timeout` out 1: no edge seen for `TIMEOUT` cycles. Sticky until the next rising edge.
- `level` out 1: conditioned (synchronized and, if enabled, filtered) copy of `sig_in`.

## Operation
- Reset handling:
  - `rst_btn` asserts asynchronously.
  - Deassertion is released through a 2-FF synchronizer, so the internal reset drops on the 2nd `clk` edge after `rst_btn` falls.
  - All logic below uses this internal reset.
- Input conditioning:
  - `sig_in` passes through a 2-FF synchronizer to give `s`. Both FFs reset to 0.
  - `s_d` is `s` delayed one cycle.
  - A rise is `s & ~s_d`. A fall is `~s & s_d`.
- Reset values: all outputs are 0, and the state machine is in IDLE.
- State IDLE:
  - Ignores level and falls. Any partial period is discarded.
  - On a rise: counter ← 1, go to HIGH.
- State HIGH:
  - Counter increments each cycle.
  - On a fall: latch `hi_tmp` ← counter, counter ← 1, go to LOW.
- State LOW:
  - Counter increments each cycle.
  - On a rise:
    - `high_cycles` ← `hi_tmp`, `low_cycles` ← counter.
    - `meas_valid` ← 1 for one cycle.
    - Counter ← 1, go to HIGH.
- Count semantics: each reported value equals the number of cycles `level` spent in that state. The minimum reported value is 1.
- Timeout:
  - Applies in HIGH or LOW when the counter reaches `TIMEOUT` with no edge in that cycle.
  - Effect: `timeout` ← 1, go to IDLE. Result outputs keep their last values, and no `meas_valid` is generated.
  - `timeout` clears on the next rise, which also starts a new measurement from HIGH.
- Because `TIMEOUT` < 2^W, the counter never wraps.
- Simultaneous events: an edge in the same cycle as the counter reaching `TIMEOUT` takes priority over the timeout.
- Reset mid-measurement: results are zeroed, `hi_tmp` is discarded, and the state machine returns to IDLE. The first `meas_valid` after reset requires a rise, a fall, and a second rise.

## Timing
- Latency from `sig_in` to the internal rise/fall strobe: a `sig_in` change sampled at edge N is visible on `level` after edge N+1, and the strobe fires in the following cycle.
- Registered outputs (`meas_valid`, `high_cycles`, `low_cycles`, `timeout` clear) update at edge N+2.
- Throughput: at most one `meas_valid` per input period. The minimum measurable period is 2 cycles (1 high, 1 low).
- The result registers are stable from one `meas_valid` to the next. There is no handshake, so the consumer must sample on `meas_valid`.

## Configuration
- `GLITCH_FILTER_EN` defined:
  - Inserts a stability filter between `s` and `level`.
  - `level` changes only after `s` has held the new value for `FILTER_LEN` consecutive cycles. Shorter pulses are ignored entirely.
  - Adds `FILTER_LEN` cycles of latency.
  - Counts then reflect filtered durations. A clean signal reports the same values as without the filter.
- `GLITCH_FILTER_EN` undefined: `level` = `s`. There is no filter logic or added latency.

## Test plan
Bench parameters: W=8, TIMEOUT=200, FILTER_LEN=4.
- Steady square wave, `sig_in` high 10 / low 6 cycles, for 5 periods → no pulse for the first (partial) period, then `meas_valid` once per period with `high_cycles`=10, `low_cycles`=6. The first pulse arrives 3 edges after the second `sig_in` rise.
- Minimum period, 1 high / 1 low → `high_cycles`=1, `low_cycles`=1, with `meas_valid` every 2 cycles.
- `sig_in` held high for 250 cycles after a rise → `timeout`=1 once the count reaches 200, no `meas_valid`, results unchanged. A later 10/6 wave clears `timeout` on its first rise and reports 10/6 one period later.
- Pulse `rst_btn` during HIGH after one valid 10/6 result → outputs read 0 immediately. Internal reset releases on the 2nd `clk` edge after deassertion. No `meas_valid` appears until a full rise-fall-rise sequence.
- With `GLITCH_FILTER_EN`: a 10/6 wave with 2-cycle low glitches inside the high phase → glitches ignored, results 10/6. Without the macro: the same stimulus splits the period and reports the shorter segments.
